// File: rtl/obi_host_arbiter.sv
// obi_host_arbiter: round-robin sharing of one OBI slave port between NUM_REQ hosts, in-order response routing.
// Define OBI_HOST_ARB_CHECK_EN to build the sticky protocol checker behind err_o.
module obi_host_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_REQ-1:0]    h_req_i,
    input  logic [NUM_REQ-1:0]    h_we_i,
    input  logic [4*NUM_REQ-1:0]  h_be_i,
    input  logic [32*NUM_REQ-1:0] h_addr_i,
    input  logic [32*NUM_REQ-1:0] h_wdata_i,
    output logic [NUM_REQ-1:0]    h_gnt_o,
    output logic [NUM_REQ-1:0]    h_rvalid_o,
    output logic [31:0]           h_rdata_o,
    output logic                  req_o,
    output logic                  we_o,
    output logic [3:0]            be_o,
    output logic [31:0]           addr_o,
    output logic [31:0]           wdata_o,
    input  logic                  gnt_i,
    input  logic                  rvalid_i,
    input  logic [31:0]           rdata_i,
    output logic                  busy_o,
    output logic                  err_o
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [IW-1:0] ptr, lock_idx, winner, sel, idx;
    logic          lock;
    logic [IW-1:0] ids [MAX_OUTSTANDING];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic          full, empty, push, pop;

    // Lowest offset from ptr wins, so iterate downwards and let later hits override.
    always_comb begin
        winner = ptr;
        idx    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = IW'((int'(ptr) + i) % NUM_REQ);
            if (h_req_i[idx]) winner = idx;
        end
    end

    assign sel     = lock ? lock_idx : winner;
    assign full    = count == CW'(MAX_OUTSTANDING);
    assign empty   = count == '0;
    assign req_o   = |h_req_i && !full;
    assign we_o    = req_o && h_we_i[sel];
    assign be_o    = req_o ? h_be_i[4*int'(sel) +: 4] : '0;
    assign addr_o  = req_o ? h_addr_i[32*int'(sel) +: 32] : '0;
    assign wdata_o = req_o ? h_wdata_i[32*int'(sel) +: 32] : '0;
    assign push    = req_o && gnt_i;
    assign pop     = rvalid_i && !empty;
    assign h_gnt_o    = push ? NUM_REQ'(1) << sel : '0;
    assign h_rvalid_o = pop ? NUM_REQ'(1) << ids[head] : '0;
    assign h_rdata_o  = rvalid_i ? rdata_i : '0;
    assign busy_o     = !empty || |h_req_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr      <= '0;
            lock     <= 1'b0;
            lock_idx <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            lock <= req_o && !gnt_i;
            if (req_o && !gnt_i) lock_idx <= sel;
            if (push) begin
                ptr  <= sel == IW'(NUM_REQ - 1) ? '0 : sel + 1'b1;
                tail <= tail == PW'(MAX_OUTSTANDING - 1) ? '0 : tail + 1'b1;
            end
            if (pop) head <= head == PW'(MAX_OUTSTANDING - 1) ? '0 : head + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) ids[tail] <= sel;
    end

`ifdef OBI_HOST_ARB_CHECK_EN
    logic        err_q, viol;
    logic [68:0] held;
    // While locked, sel is the locked host and req_o is high as long as it keeps requesting.
    assign viol = (rvalid_i && empty) ||
                  (lock && (!h_req_i[lock_idx] || {we_o, be_o, addr_o, wdata_o} != held));
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
            held  <= '0;
        end else begin
            err_q <= err_q || viol;
            if (req_o && !gnt_i && !lock) held <= {we_o, be_o, addr_o, wdata_o};
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_obi_host_arbiter.sv
// tb_obi_host_arbiter: scenario tasks with a response-routing scoreboard for obi_host_arbiter.
module tb_obi_host_arbiter;
    localparam int N = 2;
`ifdef OBI_HOST_ARB_CHECK_EN
    localparam bit EXP_ERR = 1'b1;
`else
    localparam bit EXP_ERR = 1'b0;
`endif

    logic          clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0]  h_req, h_we, h_gnt, h_rvalid;
    logic [4*N-1:0]  h_be;
    logic [32*N-1:0] h_addr, h_wdata;
    logic [31:0]   h_rdata, addr, wdata, rdata;
    logic [3:0]    be;
    logic          req, we, gnt, rvalid, busy, err;

    int n_chk = 0, n_fail = 0;
    int exp_q[$];
    int e;

    obi_host_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .h_req_i(h_req), .h_we_i(h_we), .h_be_i(h_be), .h_addr_i(h_addr), .h_wdata_i(h_wdata),
        .h_gnt_o(h_gnt), .h_rvalid_o(h_rvalid), .h_rdata_o(h_rdata),
        .req_o(req), .we_o(we), .be_o(be), .addr_o(addr), .wdata_o(wdata),
        .gnt_i(gnt), .rvalid_i(rvalid), .rdata_i(rdata),
        .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        h_req = '0; h_we = '0; h_be = '0; h_addr = '0; h_wdata = '0;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        exp_q.delete();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #2;
        n_chk++;
        if ({req, we, be, addr, wdata, h_gnt, h_rvalid, h_rdata, busy, err} !== '0) begin
            $display("FAIL reset_outputs: got req=%b gnt=%b rvalid=%b busy=%b err=%b expected all 0", req, h_gnt, h_rvalid, busy, err);
            n_fail++;
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        h_req = 2'b01; h_we = 2'b01; h_be = 8'h0f; h_addr[31:0] = 32'h0000_0100; h_wdata[31:0] = 32'hDEADBEEF; gnt = 1'b1;
        #1;
        n_chk++;
        if ({req, we, be, addr, wdata} !== {1'b1, 1'b1, 4'hf, 32'h100, 32'hDEADBEEF}) begin
            $display("FAIL single_mux: got req=%b we=%b be=%h addr=%h wdata=%h expected 1 1 f 00000100 deadbeef", req, we, be, addr, wdata);
            n_fail++;
        end
        n_chk++;
        if (h_gnt !== 2'b01) begin $display("FAIL single_gnt: got %b expected 01", h_gnt); n_fail++; end
        exp_q.push_back(0);
        step();
        h_req = '0; gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0000_CAFE;
        #1;
        e = exp_q.pop_front();
        n_chk++;
        if (h_rvalid !== (2'b01 << e) || h_rdata !== 32'h0000_CAFE) begin
            $display("FAIL single_rvalid: got %b/%h expected %b/0000cafe", h_rvalid, h_rdata, 2'b01 << e);
            n_fail++;
        end
        step();
        rvalid = 1'b0;
        #1;
        n_chk++;
        if (busy !== 1'b0) begin $display("FAIL single_busy: got %b expected 0", busy); n_fail++; end
    endtask

    task automatic test_round_robin();
        do_reset();
        h_addr = {32'h2000, 32'h1000};
        for (int c = 0; c < 5; c++) begin
            h_req = c < 4 ? 2'b11 : 2'b00; gnt = 1'b1; rvalid = c > 0; rdata = 32'hA000 + c;
            #1;
            if (c < 4) begin
                n_chk++;
                if (h_gnt !== (2'b01 << (c % 2)) || addr !== 32'h1000 * (c % 2 + 1)) begin
                    $display("FAIL rr_grant%0d: got gnt=%b addr=%h expected gnt=%b", c, h_gnt, addr, 2'b01 << (c % 2));
                    n_fail++;
                end
                exp_q.push_back(c % 2);
            end
            if (c > 0) begin
                e = exp_q.pop_front();
                n_chk++;
                if (h_rvalid !== (2'b01 << e) || h_rdata !== 32'hA000 + c) begin
                    $display("FAIL rr_resp%0d: got %b/%h expected %b/%h", c, h_rvalid, h_rdata, 2'b01 << e, 32'hA000 + c);
                    n_fail++;
                end
            end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_lock();
        do_reset();
        h_req = 2'b01; h_we = 2'b01; h_addr[31:0] = 32'h40; gnt = 1'b1;
        #1;
        exp_q.push_back(0);
        step();
        h_req = '0; gnt = 1'b0; rvalid = 1'b1; rdata = 32'h55;
        #1;
        e = exp_q.pop_front();
        n_chk++;
        if (h_rvalid !== (2'b01 << e)) begin $display("FAIL lock_pre_resp: got %b expected %b", h_rvalid, 2'b01 << e); n_fail++; end
        step();
        rvalid = 1'b0; h_we = '0; h_req = 2'b01; h_addr = {32'h200, 32'h100}; gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) h_req = 2'b11;
            #1;
            n_chk++;
            if (addr !== 32'h100 || h_gnt !== 2'b00) begin
                $display("FAIL lock_hold%0d: got addr=%h gnt=%b expected 00000100/00", k, addr, h_gnt);
                n_fail++;
            end
            step();
        end
        gnt = 1'b1;
        #1;
        n_chk++;
        if (h_gnt !== 2'b01 || addr !== 32'h100) begin $display("FAIL lock_gnt0: got %b/%h expected 01/00000100", h_gnt, addr); n_fail++; end
        exp_q.push_back(0);
        step();
        h_req = 2'b10;
        #1;
        n_chk++;
        if (h_gnt !== 2'b10 || addr !== 32'h200) begin $display("FAIL lock_gnt1: got %b/%h expected 10/00000200", h_gnt, addr); n_fail++; end
        exp_q.push_back(1);
        step();
        h_req = '0; gnt = 1'b0; rvalid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rdata = 32'hB0 + k;
            #1;
            e = exp_q.pop_front();
            n_chk++;
            if (h_rvalid !== (2'b01 << e) || h_rdata !== 32'hB0 + k) begin
                $display("FAIL lock_resp%0d: got %b/%h expected %b/%h", k, h_rvalid, h_rdata, 2'b01 << e, 32'hB0 + k);
                n_fail++;
            end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_full();
        do_reset();
        h_req = 2'b11; gnt = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            exp_q.push_back(c % 2);
            step();
        end
        #1;
        n_chk++;
        if (req !== 1'b0 || h_gnt !== 2'b00 || busy !== 1'b1) begin
            $display("FAIL full_block: got req=%b gnt=%b busy=%b expected 0 00 1", req, h_gnt, busy);
            n_fail++;
        end
        step();
        rvalid = 1'b1; rdata = 32'h12345678;
        #1;
        e = exp_q.pop_front();
        n_chk++;
        if (h_rvalid !== (2'b01 << e) || h_rdata !== 32'h12345678 || req !== 1'b0) begin
            $display("FAIL full_pop: got rvalid=%b rdata=%h req=%b expected %b/12345678/0", h_rvalid, h_rdata, req, 2'b01 << e);
            n_fail++;
        end
        step();
        rvalid = 1'b0;
        #1;
        n_chk++;
        if (req !== 1'b1 || h_gnt !== 2'b01) begin $display("FAIL full_resume: got req=%b gnt=%b expected 1/01", req, h_gnt); n_fail++; end
        exp_q.push_back(0);
        step();
        h_req = '0; gnt = 1'b0; rvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rdata = 32'hC0 + k;
            #1;
            e = exp_q.pop_front();
            n_chk++;
            if (h_rvalid !== (2'b01 << e) || h_rdata !== 32'hC0 + k) begin
                $display("FAIL full_drain%0d: got %b/%h expected %b/%h", k, h_rvalid, h_rdata, 2'b01 << e, 32'hC0 + k);
                n_fail++;
            end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        h_req = 2'b11; gnt = 1'b1;
        #1;
        step();
        #1;
        step();
        clear_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({req, we, be, addr, wdata, h_gnt, h_rvalid, h_rdata, busy, err} !== '0) begin
            $display("FAIL midreset_outputs: got req=%b gnt=%b rvalid=%b busy=%b err=%b expected all 0", req, h_gnt, h_rvalid, busy, err);
            n_fail++;
        end
        step();
        rst_n = 1'b1;
        exp_q.delete();
        rvalid = 1'b1; rdata = 32'hBAD;
        #1;
        n_chk++;
        if (h_rvalid !== 2'b00) begin $display("FAIL midreset_stray: got %b expected 00", h_rvalid); n_fail++; end
        step();
        clear_inputs();
    endtask

    task automatic test_err();
        do_reset();
        #1;
        n_chk++;
        if (err !== 1'b0) begin $display("FAIL err_clear: got %b expected 0", err); n_fail++; end
        rvalid = 1'b1;
        #1;
        n_chk++;
        if (err !== 1'b0) begin $display("FAIL err_same_cycle: got %b expected 0", err); n_fail++; end
        step();
        rvalid = 1'b0;
        #1;
        n_chk++;
        if (err !== EXP_ERR) begin $display("FAIL err_next: got %b expected %b", err, EXP_ERR); n_fail++; end
        step();
        step();
        n_chk++;
        if (err !== EXP_ERR) begin $display("FAIL err_sticky: got %b expected %b", err, EXP_ERR); n_fail++; end
        do_reset();
        #1;
        n_chk++;
        if (err !== 1'b0) begin $display("FAIL err_reset: got %b expected 0", err); n_fail++; end
    endtask

    initial begin
        clear_inputs();
        step();
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_full();
        test_reset_mid();
        test_err();
        n_chk++;
        if (exp_q.size() != 0) begin $display("FAIL scoreboard_empty: got %0d entries expected 0", exp_q.size()); n_fail++; end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/obi_host_arbiter.md
Name: obi_host_arbiter

Overview:
- Shares the single OBI slave port on gr_heep_top (req/we/be/addr/wdata, gnt/rvalid/rdata) between NUM_REQ OBI host requesters, for example bridge2xheep and a debug/readback host.
- Round-robin arbitration.
- Selection is locked while a request is pending without grant.
- In-order response routing uses an outstanding-ID FIFO.
- Sits between the host-side bridges and the gr_heep_top bridge port in tb_system and in the CW305 top.

Parameters:
- NUM_REQ, 2, number of requesting hosts (2..8).
- MAX_OUTSTANDING, 4, maximum number of granted transactions awaiting rvalid (power of 2, at least 1).

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- h_req_i  in  NUM_REQ  per-host request
- h_we_i  in  NUM_REQ  per-host write enable
- h_be_i  in  4*NUM_REQ  per-host byte enables, host k at [4k+3:4k]
- h_addr_i  in  32*NUM_REQ  per-host address, host k at [32k+31:32k]
- h_wdata_i  in  32*NUM_REQ  per-host write data
- h_gnt_o  out  NUM_REQ  per-host grant
- h_rvalid_o  out  NUM_REQ  per-host response valid
- h_rdata_o  out  32  response data, broadcast to all hosts; qualified by h_rvalid_o
- req_o  out  1  downstream request
- we_o  out  1  downstream write enable
- be_o  out  4  downstream byte enables
- addr_o  out  32  downstream address
- wdata_o  out  32  downstream write data
- gnt_i  in  1  downstream grant
- rvalid_i  in  1  downstream response valid
- rdata_i  in  32  downstream response data
- busy_o  out  1  high when any transaction is outstanding or any request is pending
- err_o  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset values: all outputs 0. Round-robin pointer = 0. Lock flag clear. ID FIFO empty.
- Arbitration is combinational in the cycle. The winner is the first asserted h_req_i[k] scanning from pointer ptr upward, modulo NUM_REQ.
- req_o = (any h_req_i) AND NOT fifo_full. The mux outputs (we/be/addr/wdata) follow the winner. When req_o = 0, the mux outputs are 0.
- Lock:
  - If req_o = 1 and gnt_i = 0, latch the winner index and set the lock flag.
  - While locked, the selection is forced to the latched index regardless of other requests. Hosts must hold their request stable until granted, per OBI.
  - The lock clears on the cycle gnt_i = 1.
- Grant: h_gnt_o[sel] = gnt_i AND req_o. All other grant bits are 0.
- On handshake (req_o AND gnt_i):
  - Push sel into the ID FIFO.
  - Set ptr = (sel + 1) mod NUM_REQ.
- Response: when rvalid_i = 1:
  - h_rvalid_o[fifo_head] = 1 in the same cycle (combinational pass-through).
  - h_rdata_o = rdata_i.
  - Pop the FIFO.
- Response latency through the block is 0 cycles. Grant latency is 0 cycles when unlocked and the FIFO is not full.
- FIFO full (MAX_OUTSTANDING entries): req_o is held low and no grants are issued.
  - If a pop occurs in the same cycle, req_o is still held low. Full is registered state; new requests resume the next cycle.
- Simultaneous push and pop: occupancy is unchanged and head/tail both advance.
- FIFO empty and rvalid_i = 1: no h_rvalid_o is asserted, and the error condition applies (see Optional Feature).
- Pointer and FIFO indices wrap modulo NUM_REQ and MAX_OUTSTANDING.
- busy_o = (fifo count != 0) OR (|h_req_i).
- Reset mid-transaction:
  - All state clears asynchronously.
  - Pending responses arriving after reset are treated as the FIFO-empty case.
  - A lock held at reset is dropped.

Optional Feature:
- Macro OBI_HOST_ARB_CHECK_EN.
- When defined, err_o sets (sticky until reset) on any of:
  - rvalid_i while the FIFO is empty;
  - a locked host deasserting h_req_i before grant;
  - a locked host changing addr/we/be/wdata before grant.
- Check registers sample these conditions at the clock edge; err_o rises one cycle after the violation.
- When the macro is not defined, err_o is tied to 0 and no check logic is synthesised.

Test Plan:
- Single host, always granted: host0 writes 0xDEADBEEF to 0x0000_0100 with gnt_i = 1 and rvalid_i one cycle later.
  - Required: req_o/addr_o/wdata_o match, h_gnt_o = 01, h_rvalid_o = 01, busy_o drops after rvalid_i.
- Round-robin: both hosts request continuously, gnt_i = 1, rvalid_i = 1 every cycle.
  - Required: grant sequence 0,1,0,1, and each rvalid is routed to the matching host.
- Lock: gnt_i held 0 for 3 cycles while host0 is pending; host1 raises its request on cycle 1.
  - Required: addr_o stays at host0's address for all 3 cycles; host0 is granted on cycle 4, then host1.
- Full: MAX_OUTSTANDING = 4, 4 reads granted, rvalid_i held 0.
  - Required: req_o = 0 with both requests pending. One rvalid_i returns with rdata 0x12345678 to the oldest ID; req_o = 1 the next cycle.
- Reset mid-burst: rst_ni pulsed low with 2 transactions outstanding.
  - Required: all outputs 0 and FIFO empty. A following stray rvalid_i asserts no h_rvalid_o.
- With OBI_HOST_ARB_CHECK_EN: rvalid_i while the FIFO is empty -> err_o = 1 on the next cycle and held until reset. Without the macro, err_o stays 0 for the same stimulus.
